// File: rtl/step_count_seg_encoder.sv
// Binary step count to four active-low 7-segment digit patterns.
// A sequential shift-and-add-3 converter produces BCD one input bit per
// clock; the encoded patterns are registered once at the end of a
// conversion and held until the next conversion finishes.
module step_count_seg_encoder #(
  parameter int WIDTH = 14
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load,
  input  logic [WIDTH-1:0] value,
  input  logic             blank_lz,
  output logic             busy,
  output logic             done,
  output logic [6:0]       seg0,
  output logic [6:0]       seg1,
  output logic [6:0]       seg2,
  output logic [6:0]       seg3
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [6:0] SEG_BLANK = 7'b1111111;
  localparam logic [6:0] SEG_DASH  = 7'b1111110;

  typedef enum logic [1:0] {
    IDLE,
    CONVERT,
    ENCODE
  } state_t;

  state_t               state;
  state_t               state_next;
  logic [CNT_W-1:0]     bit_cnt;
  logic [WIDTH-1:0]     bin_sr;
  logic [19:0]          bcd;
  logic                 ovf;
  logic                 blank_en;

  // Add 3 to every BCD nibble that is 5 or more, ahead of the left shift.
  function automatic logic [19:0] bcd_adjust(input logic [19:0] b);
    logic [19:0] r;
    r = b;
    for (int i = 0; i < 5; i++) begin
      if (r[i*4 +: 4] >= 4'd5) begin
        r[i*4 +: 4] = r[i*4 +: 4] + 4'd3;
      end
    end
    return r;
  endfunction

  // Active-low a..g pattern for one decimal digit.
  function automatic logic [6:0] seg_encode(input logic [3:0] d);
    logic [6:0] s;
    case (d)
      4'd0:    s = 7'b0000001;
      4'd1:    s = 7'b1001111;
      4'd2:    s = 7'b0010010;
      4'd3:    s = 7'b0000110;
      4'd4:    s = 7'b1001100;
      4'd5:    s = 7'b0100100;
      4'd6:    s = 7'b0100000;
      4'd7:    s = 7'b0001111;
      4'd8:    s = 7'b0000000;
      4'd9:    s = 7'b0000100;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  // State register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic: one accepted load runs WIDTH convert steps then one encode.
  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (load) state_next = CONVERT;
      CONVERT: if (bit_cnt == '0) state_next = ENCODE;
      ENCODE:  state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  // Registered handshake outputs derived from the state transition.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      busy <= 1'b0;
      done <= 1'b0;
    end else begin
      busy <= (state_next != IDLE);
      done <= (state == ENCODE);
    end
  end

  // Conversion datapath: capture on accepted load, then shift-and-add-3.
  always_ff @(posedge clk) begin
    case (state)
      IDLE: begin
        if (load) begin
          bin_sr   <= value;
          bcd      <= '0;
          blank_en <= blank_lz;
          ovf      <= (32'(value) > 32'd9999);
          bit_cnt  <= CNT_W'(WIDTH - 1);
        end
      end
      CONVERT: begin
        bcd     <= {bcd_adjust(bcd)[18:0], bin_sr[WIDTH-1]};
        bin_sr  <= bin_sr << 1;
        bit_cnt <= bit_cnt - 1'b1;
      end
      default: ;
    endcase
  end

  // Output patterns: updated only on the encode edge, blank out of reset.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      seg0 <= SEG_BLANK;
      seg1 <= SEG_BLANK;
      seg2 <= SEG_BLANK;
      seg3 <= SEG_BLANK;
    end else if (state == ENCODE) begin
      if (ovf) begin
        seg0 <= SEG_DASH;
        seg1 <= SEG_DASH;
        seg2 <= SEG_DASH;
        seg3 <= SEG_DASH;
      end else begin
        // Leading zeros blank from the top down; the ones digit always shows.
        seg0 <= seg_encode(bcd[3:0]);
        seg1 <= (blank_en && bcd[15:4] == 12'd0) ? SEG_BLANK : seg_encode(bcd[7:4]);
        seg2 <= (blank_en && bcd[15:8] == 8'd0) ? SEG_BLANK : seg_encode(bcd[11:8]);
        seg3 <= (blank_en && bcd[15:12] == 4'd0) ? SEG_BLANK : seg_encode(bcd[15:12]);
      end
    end
  end

endmodule
